sete_segmentos_velocidade_mux: RTL

- Multi-digit, time-multiplexed 7-segment speed display with speed ramp control, for the toy's speed panel.
- Switch input selects a target speed level. An internal current speed steps toward the target at a fixed rate.
- The current speed is shown in decimal on NUM_DIGITS scanned digits. The display blinks while the speed is still ramping.

---
 rtl/sete_segmentos_velocidade_mux.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/sete_segmentos_velocidade_mux.sv
// ============================================================================
// sete_segmentos_velocidade_mux: ramped speed level shown on scanned 7-seg digits
// Rev 1.0
// ============================================================================
`default_nettype none

module sete_segmentos_velocidade_mux #(
  parameter int SPEED_W    = 4,
  parameter int NUM_DIGITS = 2,
  parameter int SCAN_DIV   = 1000,
  parameter int RAMP_DIV   = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [SPEED_W-1:0]    speed_sel,
  input  logic                  enable,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] dig_en,
  output logic [SPEED_W-1:0]    speed_cur,
  output logic                  ramping
);

  localparam int RAMP_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BCD_W  = 4 * NUM_DIGITS;

  logic [SPEED_W-1:0]    sel_meta_q, sel_sync_q;
  logic                  en_meta_q, en_sync_q;
  logic [SPEED_W-1:0]    target;
  logic [RAMP_W-1:0]     ramp_cnt_q, ramp_cnt_d;
  logic                  tick;
  logic [SPEED_W-1:0]    speed_cur_q, speed_cur_d;
  logic                  blink_q, blink_d;
  logic [SCAN_W-1:0]     scan_cnt_q, scan_cnt_d;
  logic [IDX_W-1:0]      dig_idx_q, dig_idx_d;
  logic [BCD_W-1:0]      bcd;
  logic [NUM_DIGITS-1:0] blank;
  logic                  higher_nz;
  logic [3:0]            digit_val;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] dig_en_q, dig_en_d;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'd0:    glyph = 7'b1111110;
      4'd1:    glyph = 7'b0110000;
      4'd2:    glyph = 7'b1101101;
      4'd3:    glyph = 7'b1111001;
      4'd4:    glyph = 7'b0110011;
      4'd5:    glyph = 7'b1011011;
      4'd6:    glyph = 7'b1011111;
      4'd7:    glyph = 7'b1110000;
      4'd8:    glyph = 7'b1111111;
      4'd9:    glyph = 7'b1111011;
      default: glyph = 7'b0000000;
    endcase
  endfunction

  assign target  = en_sync_q ? sel_sync_q : '0;
  assign tick    = (ramp_cnt_q == RAMP_W'(RAMP_DIV - 1));
  assign ramping = (speed_cur_q != target);

  // Ramp, blink and scan next-state
  always_comb begin
    ramp_cnt_d  = tick ? '0 : ramp_cnt_q + RAMP_W'(1);
    speed_cur_d = speed_cur_q;
    if (tick && (speed_cur_q < target)) begin
      speed_cur_d = speed_cur_q + SPEED_W'(1);
    end else if (tick && (speed_cur_q > target)) begin
      speed_cur_d = speed_cur_q - SPEED_W'(1);
    end
    blink_d = 1'b1;
    if (ramping) begin
      blink_d = tick ? ~blink_q : blink_q;
    end
    scan_cnt_d = scan_cnt_q + SCAN_W'(1);
    dig_idx_d  = dig_idx_q;
    if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
      scan_cnt_d = '0;
      dig_idx_d  = (dig_idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : dig_idx_q + IDX_W'(1);
    end
  end

  // Combinational double-dabble binary to BCD
  always_comb begin
    bcd = '0;
    for (int i = SPEED_W - 1; i >= 0; i--) begin
      for (int d = 0; d < NUM_DIGITS; d++) begin
        if (bcd[4*d +: 4] > 4'd4) begin
          bcd[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
        end
      end
      bcd = {bcd[BCD_W-2:0], speed_cur_q[i]};
    end
  end

  // A digit blanks when it and every more significant digit are zero
  always_comb begin
    higher_nz = 1'b0;
    blank     = '0;
    for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
      higher_nz = higher_nz | (bcd[4*d +: 4] != 4'd0);
      blank[d]  = (d != 0) && !higher_nz;
    end
  end

  always_comb begin
    digit_val           = bcd[4*dig_idx_q +: 4];
    dig_en_d            = '0;
    dig_en_d[dig_idx_q] = 1'b1;
    seg_d               = (blink_q && !blank[dig_idx_q]) ? glyph(digit_val) : 7'b0000000;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_meta_q  <= '0;
      sel_sync_q  <= '0;
      en_meta_q   <= 1'b0;
      en_sync_q   <= 1'b0;
      ramp_cnt_q  <= '0;
      speed_cur_q <= '0;
      blink_q     <= 1'b1;
      scan_cnt_q  <= '0;
      dig_idx_q   <= '0;
      seg_q       <= 7'b1111110;
      dig_en_q    <= NUM_DIGITS'(1);
    end else begin
      sel_meta_q  <= speed_sel;
      sel_sync_q  <= sel_meta_q;
      en_meta_q   <= enable;
      en_sync_q   <= en_meta_q;
      ramp_cnt_q  <= ramp_cnt_d;
      speed_cur_q <= speed_cur_d;
      blink_q     <= blink_d;
      scan_cnt_q  <= scan_cnt_d;
      dig_idx_q   <= dig_idx_d;
      seg_q       <= seg_d;
      dig_en_q    <= dig_en_d;
    end
  end

  assign seg       = seg_q;
  assign dig_en    = dig_en_q;
  assign speed_cur = speed_cur_q;

endmodule

`default_nettype wire
